// File: rtl/lsu_subword_bridge.sv
// rtl/lsu_subword_bridge.sv - byte/half/word load-store bridge onto a word-addressed memory
// Sub-word stores use read-modify-write; loads return sign- or zero-extended data.
module lsu_subword_bridge #(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_load,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t      state, state_next;
   logic [1:0]  addr_lo;
   logic [1:0]  size_q;
   logic        uns_q, load_q, err_q;
   logic [31:0] wdata_q, data_q;
   logic [3:0]  cnt;
   logic        req_err;
   logic [31:0] shifted, merged, ext;

   always_comb begin
      req_err = (req_size == 2'b11) ||
                (req_size == 2'b01 && req_addr[0]) ||
                (req_size == 2'b10 && req_addr[1:0] != 2'b00);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         addr_lo     <= '0;
         size_q      <= '0;
         uns_q       <= 1'b0;
         load_q      <= 1'b0;
         err_q       <= 1'b0;
         wdata_q     <= '0;
         data_q      <= '0;
         cnt         <= '0;
         mem_address <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_lo <= req_addr[1:0];
                  size_q  <= req_size;
                  uns_q   <= req_unsigned;
                  load_q  <= req_load;
                  wdata_q <= req_wdata;
                  err_q   <= req_err;
                  cnt     <= 4'(MEM_LAT - 1);
                  // Error requests never touch memory, so the bus address keeps its old value.
                  if (!req_err)
                     mem_address <= {req_addr[31:2], 2'b00};
               end
            end
            READ: begin
               if (cnt == 4'd0)
                  data_q <= mem_read_data;
               else
                  cnt <= cnt - 4'd1;
            end
            default: ;
         endcase
      end
   end

   // Halfwords are aligned, so the byte-lane shift also selects the correct halfword.
   always_comb begin
      shifted = data_q >> {addr_lo, 3'b000};
      case (size_q)
         2'b00:   ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
         2'b01:   ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
         default: ext = data_q;
      endcase
   end

   always_comb begin
      merged = data_q;
      if (size_q == 2'b00) begin
         case (addr_lo)
            2'd0:    merged[7:0]   = wdata_q[7:0];
            2'd1:    merged[15:8]  = wdata_q[7:0];
            2'd2:    merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
         endcase
      end else if (addr_lo[1]) begin
         merged[31:16] = wdata_q[15:0];
      end else begin
         merged[15:0] = wdata_q[15:0];
      end
   end

   always_comb begin
      state_next     = state;
      req_ready      = 1'b0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_write_data = '0;
      resp_valid     = 1'b0;
      resp_rdata     = '0;
      resp_error     = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_err)
                  state_next = RESP;
               else if (req_load || req_size != 2'b10)
                  state_next = READ;
               else
                  state_next = WRITE;
            end
         end
         READ: begin
            mem_read = 1'b1;
            if (cnt == 4'd0)
               state_next = load_q ? RESP : WRITE;
         end
         WRITE: begin
            mem_write      = 1'b1;
            mem_write_data = (size_q == 2'b10) ? wdata_q : merged;
            state_next     = RESP;
         end
         default: begin
            resp_valid = 1'b1;
            resp_error = err_q;
            resp_rdata = (load_q && !err_q) ? ext : 32'd0;
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_lsu_subword_bridge.sv
// tb/tb_lsu_subword_bridge.sv - self-checking bench for lsu_subword_bridge
// Instance 0 runs with MEM_LAT=1, instance 1 with MEM_LAT=3.
module tb_lsu_subword_bridge;

   logic        clk = 1'b0;
   logic        rst [2];
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_load [2];
   logic [1:0]  req_size [2];
   logic        req_unsigned [2];
   logic [31:0] req_addr [2];
   logic [31:0] req_wdata [2];
   logic        resp_valid [2];
   logic [31:0] resp_rdata [2];
   logic        resp_error [2];
   logic [31:0] mem_address [2];
   logic [31:0] mem_write_data [2];
   logic        mem_read [2];
   logic        mem_write [2];
   logic [31:0] mem_read_data [2];

   logic [31:0] mem [2][64];
   logic [31:0] ref_mem [2][64];
   int          lat_of [2] = '{1, 3};

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   lsu_subword_bridge #(.MEM_LAT(1)) dut0 (
      .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_load(req_load[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
      .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]), .mem_address(mem_address[0]),
      .mem_write_data(mem_write_data[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
      .mem_read_data(mem_read_data[0]));

   lsu_subword_bridge #(.MEM_LAT(3)) dut1 (
      .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_load(req_load[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
      .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]), .mem_address(mem_address[1]),
      .mem_write_data(mem_write_data[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
      .mem_read_data(mem_read_data[1]));

   assign mem_read_data[0] = mem[0][mem_address[0][7:2]];
   assign mem_read_data[1] = mem[1][mem_address[1][7:2]];

   always @(posedge clk) begin
      if (mem_write[0]) mem[0][mem_address[0][7:2]] = mem_write_data[0];
      if (mem_write[1]) mem[1][mem_address[1][7:2]] = mem_write_data[1];
   end

   // Reference: lanes picked by arithmetic shift/mask, extension by subtracting 2^n.
   function automatic void model(input logic load, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] word, input int lat,
                                 output logic err, output logic [31:0] rdata,
                                 output logic [31:0] wword, output int elat,
                                 output int erd, output int ewr);
      logic [31:0] v, mask;
      int          sh;
      err   = (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
      rdata = 0; wword = 0; elat = 1; erd = 0; ewr = 0;
      if (err) return;
      if (load) begin
         elat = lat + 1; erd = lat;
         if (size == 0) begin
            sh = 8 * int'(addr % 4);
            v = (word >> sh) % 256;
            rdata = (!uns && v >= 128) ? v - 32'd256 : v;
         end else if (size == 1) begin
            sh = 16 * int'((addr / 2) % 2);
            v = (word >> sh) % 65536;
            rdata = (!uns && v >= 32768) ? v - 32'd65536 : v;
         end else begin
            rdata = word;
         end
      end else if (size == 2) begin
         wword = wdata; elat = 2; ewr = 1;
      end else begin
         elat = lat + 2; erd = lat; ewr = 1;
         if (size == 0) begin
            sh = 8 * int'(addr % 4); mask = 32'd255 << sh;
            wword = (word & ~mask) | ((wdata % 256) << sh);
         end else begin
            sh = 16 * int'((addr / 2) % 2); mask = 32'd65535 << sh;
            wword = (word & ~mask) | ((wdata % 65536) << sh);
         end
      end
   endfunction

   task automatic run_txn(input int d, input logic load, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output int nrd, output int nwr,
                          output logic [31:0] rd_addr, output logic [31:0] wr_addr,
                          output logic [31:0] wr_data, output logic [31:0] rdata,
                          output logic err);
      int w;
      lat = -1; nrd = 0; nwr = 0; rd_addr = 'x; wr_addr = 'x; wr_data = 'x;
      rdata = 'x; err = 1'bx;
      @(negedge clk);
      w = 0;
      while (!req_ready[d] && w < 30) begin
         @(negedge clk);
         w++;
      end
      req_load[d] = load; req_size[d] = size; req_unsigned[d] = uns;
      req_addr[d] = addr; req_wdata[d] = wdata; req_valid[d] = 1'b1;
      @(posedge clk);
      #1 req_valid[d] = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (mem_read[d]) begin nrd++; rd_addr = mem_address[d]; end
         if (mem_write[d]) begin nwr++; wr_addr = mem_address[d]; wr_data = mem_write_data[d]; end
         if (resp_valid[d]) begin
            lat = c; rdata = resp_rdata[d]; err = resp_error[d];
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst[0] = 1'b1; rst[1] = 1'b1;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         tests++;
         if ({req_ready[d], resp_valid[d], resp_error[d], mem_read[d], mem_write[d]} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_strobes dut%0d got=%b want=10000", d,
                     {req_ready[d], resp_valid[d], resp_error[d], mem_read[d], mem_write[d]});
         end
         tests++;
         if ({resp_rdata[d], mem_address[d], mem_write_data[d]} !== 96'd0) begin
            fails++;
            $display("FAIL reset_buses dut%0d rdata=%h addr=%h wdata=%h want all 0", d,
                     resp_rdata[d], mem_address[d], mem_write_data[d]);
         end
      end
      rst[0] = 1'b0; rst[1] = 1'b0;
   endtask

   task automatic test_loads();
      logic [31:0] a [6]  = '{32'h13, 32'h13, 32'h10, 32'h12, 32'h10, 32'h10};
      logic [1:0]  sz [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
      logic        u [6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [31:0] ex [6] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFFFFBB,
                              32'hFFFF8899, 32'h0000AABB, 32'h8899AABB};
      int lat, nrd, nwr;
      logic [31:0] ra, wa, wd, rd;
      logic er;
      mem[0][4] = 32'h8899AABB;
      for (int i = 0; i < 6; i++) begin
         run_txn(0, 1'b1, sz[i], u[i], a[i], 32'h0, lat, nrd, nwr, ra, wa, wd, rd, er);
         tests++;
         if (rd !== ex[i] || er !== 1'b0) begin
            fails++;
            $display("FAIL load_data #%0d got=%h err=%b want=%h err=0", i, rd, er, ex[i]);
         end
         tests++;
         if (lat != 2 || nrd != 1 || nwr != 0 || ra !== 32'h10) begin
            fails++;
            $display("FAIL load_timing #%0d lat=%0d rd=%0d wr=%0d addr=%h want 2/1/0/10",
                     i, lat, nrd, nwr, ra);
         end
      end
   endtask

   task automatic test_stores();
      int lat, nrd, nwr;
      logic [31:0] ra, wa, wd, rd;
      logic er;
      mem[0][4] = 32'h8899AABB;
      run_txn(0, 1'b0, 2'd0, 1'b0, 32'h11, 32'h12345655, lat, nrd, nwr, ra, wa, wd, rd, er);
      tests++;
      if (nrd != 1 || nwr != 1 || wd !== 32'h889955BB || wa !== 32'h10 || lat != 3 || rd !== 0) begin
         fails++;
         $display("FAIL sb rd=%0d wr=%0d wdata=%h waddr=%h lat=%0d rdata=%h want 1/1/889955BB/10/3/0",
                  nrd, nwr, wd, wa, lat, rd);
      end
      mem[0][4] = 32'h8899AABB;
      run_txn(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0000CAFE, lat, nrd, nwr, ra, wa, wd, rd, er);
      tests++;
      if (nrd != 1 || nwr != 1 || wd !== 32'hCAFEAABB || lat != 3) begin
         fails++;
         $display("FAIL sh rd=%0d wr=%0d wdata=%h lat=%0d want 1/1/CAFEAABB/3", nrd, nwr, wd, lat);
      end
      run_txn(0, 1'b0, 2'd2, 1'b0, 32'h14, 32'hDEADBEEF, lat, nrd, nwr, ra, wa, wd, rd, er);
      tests++;
      if (nrd != 0 || nwr != 1 || wd !== 32'hDEADBEEF || wa !== 32'h14 || lat != 2) begin
         fails++;
         $display("FAIL sw rd=%0d wr=%0d wdata=%h waddr=%h lat=%0d want 0/1/DEADBEEF/14/2",
                  nrd, nwr, wd, wa, lat);
      end
      tests++;
      if (mem[0][5] !== 32'hDEADBEEF) begin
         fails++;
         $display("FAIL sw_mem got=%h want=DEADBEEF", mem[0][5]);
      end
   endtask

   task automatic test_errors();
      logic        ld [3] = '{1'b1, 1'b1, 1'b0};
      logic [1:0]  sz [3] = '{2'd2, 2'd1, 2'd3};
      logic [31:0] a [3]  = '{32'h16, 32'h11, 32'h10};
      int lat, nrd, nwr;
      logic [31:0] ra, wa, wd, rd;
      logic er;
      for (int i = 0; i < 3; i++) begin
         run_txn(0, ld[i], sz[i], 1'b0, a[i], 32'hFFFFFFFF, lat, nrd, nwr, ra, wa, wd, rd, er);
         tests++;
         if (er !== 1'b1 || lat != 1 || nrd != 0 || nwr != 0 || rd !== 0) begin
            fails++;
            $display("FAIL error #%0d err=%b lat=%0d rd=%0d wr=%0d rdata=%h want 1/1/0/0/0",
                     i, er, lat, nrd, nwr, rd);
         end
      end
   endtask

   task automatic test_lat3();
      int lat, nrd, nwr;
      logic [31:0] ra, wa, wd, rd;
      logic er;
      mem[1][4] = 32'h8899AABB;
      run_txn(1, 1'b1, 2'd0, 1'b0, 32'h13, 32'h0, lat, nrd, nwr, ra, wa, wd, rd, er);
      tests++;
      if (nrd != 3 || lat != 4 || rd !== 32'hFFFFFF88 || ra !== 32'h10) begin
         fails++;
         $display("FAIL lat3_lb rd=%0d lat=%0d rdata=%h addr=%h want 3/4/FFFFFF88/10",
                  nrd, lat, rd, ra);
      end
   endtask

   task automatic test_reset_abort();
      int nwr = 0, nresp = 0;
      mem[1][4] = 32'h8899AABB;
      @(negedge clk);
      req_load[1] = 1'b0; req_size[1] = 2'd0; req_unsigned[1] = 1'b0;
      req_addr[1] = 32'h11; req_wdata[1] = 32'h12345655; req_valid[1] = 1'b1;
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst[1] = 1'b1;
      @(negedge clk);
      rst[1] = 1'b0;
      tests++;
      if (req_ready[1] !== 1'b1 || mem_read[1] !== 1'b0 || mem_write[1] !== 1'b0) begin
         fails++;
         $display("FAIL abort_idle ready=%b rd=%b wr=%b want 1/0/0", req_ready[1], mem_read[1], mem_write[1]);
      end
      for (int c = 0; c < 10; c++) begin
         if (mem_write[1]) nwr++;
         if (resp_valid[1]) nresp++;
         @(negedge clk);
      end
      tests++;
      if (nwr != 0 || nresp != 0 || mem[1][4] !== 32'h8899AABB) begin
         fails++;
         $display("FAIL abort_quiet writes=%0d resps=%0d word=%h want 0/0/8899AABB", nwr, nresp, mem[1][4]);
      end
   endtask

   task automatic test_back_to_back();
      int resp_c = -1, acc_c = -1, lat_b = -1;
      logic [31:0] ra = 'x, rb = 'x;
      mem[0][4] = 32'h8899AABB;
      @(negedge clk);
      req_load[0] = 1'b1; req_size[0] = 2'd2; req_unsigned[0] = 1'b0;
      req_addr[0] = 32'h10; req_wdata[0] = 32'h0; req_valid[0] = 1'b1;
      @(posedge clk);
      #1 req_size[0] = 2'd0; req_unsigned[0] = 1'b1; req_addr[0] = 32'h13;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (resp_valid[0] && resp_c < 0) begin resp_c = c; ra = resp_rdata[0]; end
         if (req_ready[0]) begin acc_c = c; break; end
      end
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (resp_valid[0]) begin lat_b = c; rb = resp_rdata[0]; break; end
      end
      tests++;
      if (resp_c != 2 || acc_c != resp_c + 1) begin
         fails++;
         $display("FAIL b2b_timing resp_cycle=%0d accept_cycle=%0d want 2/3", resp_c, acc_c);
      end
      tests++;
      if (ra !== 32'h8899AABB || rb !== 32'h00000088 || lat_b != 2) begin
         fails++;
         $display("FAIL b2b_data a=%h b=%h lat_b=%0d want 8899AABB/00000088/2", ra, rb, lat_b);
      end
   endtask

   task automatic test_random();
      int lat, nrd, nwr, elat, erd, ewr, bad;
      logic [31:0] ra, wa, wd, rd, erdata, ewword, addr, wdata;
      logic er, eerr, load, uns;
      logic [1:0] size;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 64; i++) begin
            mem[d][i] = $urandom;
            ref_mem[d][i] = mem[d][i];
         end
         for (int n = 0; n < 80; n++) begin
            load = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            uns  = 1'($urandom_range(0, 1));
            addr = $urandom_range(0, 255);
            wdata = $urandom;
            model(load, size, uns, addr, wdata, ref_mem[d][addr / 4], lat_of[d],
                  eerr, erdata, ewword, elat, erd, ewr);
            if (ewr == 1) ref_mem[d][addr / 4] = ewword;
            run_txn(d, load, size, uns, addr, wdata, lat, nrd, nwr, ra, wa, wd, rd, er);
            tests++;
            if (er !== eerr || rd !== erdata || lat != elat || nrd != erd || nwr != ewr) begin
               fails++;
               $display("FAIL rand dut%0d #%0d ld=%b sz=%0d a=%h err=%b/%b rdata=%h/%h lat=%0d/%0d rd=%0d/%0d wr=%0d/%0d",
                        d, n, load, size, addr, er, eerr, rd, erdata, lat, elat, nrd, erd, nwr, ewr);
            end
            if (ewr == 1) begin
               tests++;
               if (wd !== ewword || wa !== (addr & 32'hFFFFFFFC)) begin
                  fails++;
                  $display("FAIL rand_write dut%0d #%0d wdata=%h want=%h waddr=%h", d, n, wd, ewword, wa);
               end
            end
         end
         bad = 0;
         for (int i = 0; i < 64; i++)
            if (mem[d][i] !== ref_mem[d][i]) bad++;
         tests++;
         if (bad != 0) begin
            fails++;
            $display("FAIL rand_memory dut%0d differing_words=%0d want 0", d, bad);
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; req_valid[d] = 1'b0; req_load[d] = 1'b0; req_size[d] = 2'd0;
         req_unsigned[d] = 1'b0; req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
         for (int i = 0; i < 64; i++) mem[d][i] = 32'h0;
      end
      test_reset();
      test_loads();
      test_stores();
      test_errors();
      test_lat3();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
